// File: rtl/multi_write_arbiter_if.sv
// Handshake bundle between NREQ write requesters, the arbiter and one shared register write port.
// Latency: none; this is wiring only.
// Backpressure: carried by REQ_CONSUMED toward the requesters and by OUT_*_CONSUMED from downstream.
//
// Ports / signals:
//   REQ_WRITE            NREQ*width  requester data, slice i = [i*width +: width]
//   REQ_EN_WRITE         NREQ        requester enable-token values
//   REQ_VALID            NREQ        requester i offers a {data, enable} pair
//   REQ_CONSUMED         NREQ        one-hot or zero, requester i's pair taken
//   OUT_WRITE / _VALID / _CONSUMED   data token to the shared port
//   OUT_EN_WRITE / _VALID / _CONSUMED enable token to the shared port
//   GRANT_ID             IDW         source index of the buffered token
//
// master: the arbiter side. slave: the requester/downstream environment side.
interface multi_write_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int width = 32,
   parameter int IDW   = 2
);
   logic [NREQ*width-1:0] REQ_WRITE;
   logic [NREQ-1:0]       REQ_EN_WRITE;
   logic [NREQ-1:0]       REQ_VALID;
   logic [NREQ-1:0]       REQ_CONSUMED;

   logic [width-1:0]      OUT_WRITE;
   logic                  OUT_WRITE_VALID;
   logic                  OUT_WRITE_CONSUMED;
   logic                  OUT_EN_WRITE;
   logic                  OUT_EN_WRITE_VALID;
   logic                  OUT_EN_WRITE_CONSUMED;
   logic [IDW-1:0]        GRANT_ID;

   modport master (
      input  REQ_WRITE,
      input  REQ_EN_WRITE,
      input  REQ_VALID,
      output REQ_CONSUMED,
      output OUT_WRITE,
      output OUT_WRITE_VALID,
      input  OUT_WRITE_CONSUMED,
      output OUT_EN_WRITE,
      output OUT_EN_WRITE_VALID,
      input  OUT_EN_WRITE_CONSUMED,
      output GRANT_ID
   );

   modport slave (
      output REQ_WRITE,
      output REQ_EN_WRITE,
      output REQ_VALID,
      input  REQ_CONSUMED,
      input  OUT_WRITE,
      input  OUT_WRITE_VALID,
      output OUT_WRITE_CONSUMED,
      input  OUT_EN_WRITE,
      input  OUT_EN_WRITE_VALID,
      output OUT_EN_WRITE_CONSUMED,
      input  GRANT_ID
   );
endinterface

// File: rtl/multi_write_arbiter.sv
// Round-robin arbiter sharing one {data, enable} register write port among NREQ requesters.
// Latency: one cycle; a pair accepted at edge k is on OUT_* after edge k, consumable at edge k+1.
// Backpressure: one-entry output buffer; REQ_CONSUMED drops only when the buffer is full and not draining.
//
// Ports:
//   CLK    clock
//   RST_N  synchronous active-low reset; discards any buffered token
//   bus    multi_write_arbiter_if.master (requester inputs, grant strobes, shared-port outputs)
module multi_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int width = 32,
   parameter int IDW   = 2
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   multi_write_arbiter_if.master  bus
);

   // One extra bit so ptr + offset and win + 1 can be compared against NREQ
   // before wrapping, which keeps non-power-of-two NREQ correct.
   localparam int IW = IDW + 1;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [width-1:0]  buf_data;
   logic              buf_en;
   logic [IDW-1:0]    buf_src;
   logic [IDW-1:0]    ptr;

   logic              full;
   logic              drain;
   logic              space;
   logic              accept;

   logic [2*NREQ-1:0] vld_dbl;
   logic [NREQ-1:0]   vld_rot;
   logic              win_vld;
   logic [IW-1:0]     win_off;
   logic [IW-1:0]     win_sum;
   logic [IDW-1:0]    win;
   logic [IW-1:0]     ptr_inc;
   logic [IDW-1:0]    ptr_nxt;

   logic [NREQ-1:0]   consumed;
   logic [width-1:0]  sel_data;
   logic              sel_en;

   // ---------------------------------------------------------------
   // Buffer occupancy and handshake conditions
   // ---------------------------------------------------------------
   assign full  = (state == S_FULL);

   // The downstream register always takes both tokens together; a lone
   // consume is a protocol error and is deliberately treated as no drain.
   assign drain = full & bus.OUT_WRITE_CONSUMED & bus.OUT_EN_WRITE_CONSUMED;

   // Accepting in the draining cycle gives one token per cycle throughput.
   assign space = ~full | drain;

   // ---------------------------------------------------------------
   // Round-robin winner search
   // ---------------------------------------------------------------
   // Rotating a doubled copy of REQ_VALID right by ptr puts requester ptr
   // at bit 0, so the lowest set bit is the offset of the winner.
   always_comb begin : arbitrate
      vld_dbl = {bus.REQ_VALID, bus.REQ_VALID};
      vld_rot = NREQ'(vld_dbl >> ptr);
      win_vld = 1'b0;
      win_off = '0;
      // Scanning downward lets the lowest set bit overwrite the others.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (vld_rot[k]) begin
            win_vld = 1'b1;
            win_off = IW'(k);
         end
      end
      win_sum = {1'b0, ptr} + win_off;
      if (win_sum >= IW'(NREQ)) begin
         win_sum = win_sum - IW'(NREQ);
      end
      win = win_sum[IDW-1:0];
   end

   // Priority moves just past the winner; explicit compare handles the wrap.
   always_comb begin : next_ptr
      ptr_inc = {1'b0, win} + IW'(1);
      ptr_nxt = ptr_inc[IDW-1:0];
      if (ptr_inc >= IW'(NREQ)) begin
         ptr_nxt = '0;
      end
   end

   // RST_N gating keeps REQ_CONSUMED low during the reset cycle, so no
   // requester believes its token was taken while the buffer is being cleared.
   assign accept = RST_N & space & win_vld;

   // ---------------------------------------------------------------
   // Grant strobes and winner data select
   // ---------------------------------------------------------------
   // REQ_CONSUMED is derived only from valid/ptr/full/consumes, never from
   // the data or enable values being muxed here.
   always_comb begin : grant_mux
      consumed = '0;
      sel_data = '0;
      sel_en   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            consumed[i] = accept;
            sel_data    = bus.REQ_WRITE[i*width +: width];
            sel_en      = bus.REQ_EN_WRITE[i];
         end
      end
   end

   // ---------------------------------------------------------------
   // Occupancy FSM
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin : state_reg
      if (!RST_N) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin : state_next
      state_nxt = state;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            // A refill in the draining cycle keeps the buffer full.
            if (accept) begin
               state_nxt = S_FULL;
            end else if (drain) begin
               state_nxt = S_EMPTY;
            end
         end
         default: begin
            state_nxt = S_EMPTY;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Buffer payload and priority pointer
   // ---------------------------------------------------------------
   // Payload is only written on accept, so an emptied buffer keeps showing
   // its last token on OUT_* (with VALID low). The pointer stays put when
   // nobody is granted: there is no idle rotation.
   always_ff @(posedge CLK) begin : buf_reg
      if (!RST_N) begin
         buf_data <= '0;
         buf_en   <= 1'b0;
         buf_src  <= '0;
         ptr      <= '0;
      end else if (accept) begin
         buf_data <= sel_data;
         buf_en   <= sel_en;
         buf_src  <= win;
         ptr      <= ptr_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign bus.REQ_CONSUMED       = consumed;
   assign bus.OUT_WRITE          = buf_data;
   assign bus.OUT_WRITE_VALID    = full;
   assign bus.OUT_EN_WRITE       = buf_en;
   assign bus.OUT_EN_WRITE_VALID = full;
   assign bus.GRANT_ID           = buf_src;

endmodule

// File: tb/tb_multi_write_arbiter.sv
// Self-checking bench for multi_write_arbiter: directed scenarios plus a randomized run
// compared against a behavioural model (modulo scan from the priority pointer).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_multi_write_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int IDW  = 2;

   logic CLK = 1'b0;
   logic RST_N;

   always #5 CLK = ~CLK;

   multi_write_arbiter_if #(.NREQ(NREQ), .width(W), .IDW(IDW)) bus ();

   multi_write_arbiter #(.NREQ(NREQ), .width(W), .IDW(IDW)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model of the one-entry buffer and the priority pointer.
   bit             m_full;
   logic [W-1:0]   m_data;
   bit             m_en;
   logic [IDW-1:0] m_src;
   int             m_ptr;

   // The downstream register always asserts both consumes together.
   always @(negedge CLK) begin
      if (RST_N === 1'b1 && bus.OUT_WRITE_VALID === 1'b1) begin
         assert (bus.OUT_WRITE_CONSUMED === bus.OUT_EN_WRITE_CONSUMED)
            else $error("protocol violation: data and enable consumes disagree while buffer full");
      end
   end

   function automatic void model_reset();
      m_full = 1'b0;
      m_data = '0;
      m_en   = 1'b0;
      m_src  = '0;
      m_ptr  = 0;
   endfunction

   // First valid requester found walking ptr, ptr+1, ... modulo NREQ.
   function automatic int model_pick();
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (bus.REQ_VALID[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] model_consumed();
      logic [NREQ-1:0] r;
      int              w;
      bit              sp;
      r  = '0;
      sp = !m_full || (bus.OUT_WRITE_CONSUMED === 1'b1 && bus.OUT_EN_WRITE_CONSUMED === 1'b1);
      w  = model_pick();
      if (RST_N === 1'b1 && sp && w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   // Advance one clock, updating the model from the inputs present at the edge.
   task automatic tick();
      int       w;
      bit       dr;
      logic [W-1:0] d;
      bit       e;
      dr = m_full && bus.OUT_WRITE_CONSUMED === 1'b1 && bus.OUT_EN_WRITE_CONSUMED === 1'b1;
      w  = (RST_N === 1'b1 && (!m_full || dr)) ? model_pick() : -1;
      d  = '0;
      e  = 1'b0;
      if (w >= 0) begin
         d = bus.REQ_WRITE[w*W +: W];
         e = bus.REQ_EN_WRITE[w];
      end
      @(posedge CLK);
      if (RST_N !== 1'b1) begin
         model_reset();
      end else if (w >= 0) begin
         m_full = 1'b1;
         m_data = d;
         m_en   = e;
         m_src  = IDW'(w);
         m_ptr  = (w + 1) % NREQ;
      end else if (dr) begin
         m_full = 1'b0;
      end
      @(negedge CLK);
   endtask

   task automatic set_cons(input bit c);
      bus.OUT_WRITE_CONSUMED    = c;
      bus.OUT_EN_WRITE_CONSUMED = c;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      bus.REQ_VALID = 4'b1111;
      set_cons(1'b1);
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0000) begin errors++; $display("FAIL reset_consumed: got %b expected 0000", bus.REQ_CONSUMED); end
      tick();
      tick();
      RST_N = 1'b1;
      bus.REQ_VALID = 4'b0000;
      #1;
      checks++; if (bus.OUT_WRITE_VALID !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", bus.OUT_WRITE_VALID); end
      checks++; if (bus.OUT_EN_WRITE_VALID !== 1'b0) begin errors++; $display("FAIL reset_envalid: got %b expected 0", bus.OUT_EN_WRITE_VALID); end
      checks++; if (bus.OUT_WRITE !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.OUT_WRITE); end
      checks++; if (bus.OUT_EN_WRITE !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.OUT_EN_WRITE); end
      checks++; if (bus.GRANT_ID !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus.GRANT_ID); end
   endtask

   task automatic test_single();
      bus.REQ_WRITE = '0;
      bus.REQ_WRITE[2*W +: W] = 32'hDEADBEEF;
      bus.REQ_EN_WRITE = 4'b0100;
      bus.REQ_VALID = 4'b0100;
      set_cons(1'b1);
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0100) begin errors++; $display("FAIL single_consumed: got %b expected 0100", bus.REQ_CONSUMED); end
      tick();
      bus.REQ_VALID = 4'b1111;
      #1;
      checks++; if (bus.OUT_WRITE !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", bus.OUT_WRITE); end
      checks++; if (bus.OUT_EN_WRITE !== 1'b1) begin errors++; $display("FAIL single_en: got %b expected 1", bus.OUT_EN_WRITE); end
      checks++; if (bus.OUT_WRITE_VALID !== 1'b1 || bus.OUT_EN_WRITE_VALID !== 1'b1) begin errors++; $display("FAIL single_valids: got %b%b expected 11", bus.OUT_WRITE_VALID, bus.OUT_EN_WRITE_VALID); end
      checks++; if (bus.GRANT_ID !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", bus.GRANT_ID); end
      // Pointer now at 3: with everyone valid, requester 3 must win.
      checks++; if (bus.REQ_CONSUMED !== 4'b1000) begin errors++; $display("FAIL single_ptr: got %b expected 1000", bus.REQ_CONSUMED); end
      tick();
      bus.REQ_VALID = 4'b0000;
      tick();
   endtask

   task automatic test_contention();
      int tokens;
      logic [NREQ-1:0] exp;
      tokens = 0;
      set_cons(1'b1);
      for (int k = 0; k < 8; k++) begin
         bus.REQ_VALID = 4'b1111;
         bus.REQ_WRITE = {$urandom, $urandom, $urandom, $urandom};
         #1;
         exp = 4'b0001 << (k % NREQ);
         checks++; if (bus.REQ_CONSUMED !== exp) begin errors++; $display("FAIL contend_consumed[%0d]: got %b expected %b", k, bus.REQ_CONSUMED, exp); end
         if (bus.OUT_WRITE_VALID === 1'b1) tokens++;
         tick();
         checks++; if (bus.GRANT_ID !== IDW'(k % NREQ)) begin errors++; $display("FAIL contend_grant[%0d]: got %0d expected %0d", k, bus.GRANT_ID, k % NREQ); end
      end
      bus.REQ_VALID = 4'b0000;
      #1;
      if (bus.OUT_WRITE_VALID === 1'b1) tokens++;
      tick();
      checks++; if (tokens != 8) begin errors++; $display("FAIL contend_tokens: got %0d expected 8", tokens); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < NREQ; i++) bus.REQ_WRITE[i*W +: W] = 32'h1000_0000 + i;
      bus.REQ_EN_WRITE = 4'b1111;
      bus.REQ_VALID = 4'b0010;
      set_cons(1'b1);
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0010) begin errors++; $display("FAIL bp_load: got %b expected 0010", bus.REQ_CONSUMED); end
      tick();
      set_cons(1'b0);
      bus.REQ_VALID = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (bus.REQ_CONSUMED !== 4'b0000) begin errors++; $display("FAIL bp_hold_consumed[%0d]: got %b expected 0000", c, bus.REQ_CONSUMED); end
         checks++; if (bus.OUT_WRITE !== 32'h1000_0001 || bus.GRANT_ID !== 2'd1) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h/%0d expected 10000001/1", c, bus.OUT_WRITE, bus.GRANT_ID); end
         tick();
      end
      set_cons(1'b1);
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0100 || bus.OUT_WRITE_VALID !== 1'b1) begin errors++; $display("FAIL bp_release: got %b/%b expected 0100/1", bus.REQ_CONSUMED, bus.OUT_WRITE_VALID); end
      tick();
      checks++; if (bus.GRANT_ID !== 2'd2 || bus.OUT_WRITE !== 32'h1000_0002) begin errors++; $display("FAIL bp_after: got %0d/%h expected 2/10000002", bus.GRANT_ID, bus.OUT_WRITE); end
      bus.REQ_VALID = 4'b0000;
      tick();
   endtask

   task automatic test_wrap();
      // Pointer is 3 here; requesters 2 and 3 idle.
      bus.REQ_VALID = 4'b0011;
      set_cons(1'b1);
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b expected 0001", bus.REQ_CONSUMED); end
      tick();
      checks++; if (bus.GRANT_ID !== 2'd0) begin errors++; $display("FAIL wrap_grant0: got %0d expected 0", bus.GRANT_ID); end
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0010) begin errors++; $display("FAIL wrap_second: got %b expected 0010", bus.REQ_CONSUMED); end
      tick();
      checks++; if (bus.GRANT_ID !== 2'd1) begin errors++; $display("FAIL wrap_grant1: got %0d expected 1", bus.GRANT_ID); end
      bus.REQ_VALID = 4'b0000;
      tick();
   endtask

   task automatic test_en_zero();
      bus.REQ_WRITE[0 +: W] = 32'h5;
      bus.REQ_EN_WRITE = 4'b1110;
      bus.REQ_VALID = 4'b0001;
      set_cons(1'b1);
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0001) begin errors++; $display("FAIL enz_consumed: got %b expected 0001", bus.REQ_CONSUMED); end
      tick();
      checks++; if (bus.OUT_WRITE !== 32'h5 || bus.OUT_EN_WRITE !== 1'b0) begin errors++; $display("FAIL enz_token: got %h/%b expected 5/0", bus.OUT_WRITE, bus.OUT_EN_WRITE); end
      checks++; if (bus.OUT_WRITE_VALID !== 1'b1 || bus.GRANT_ID !== 2'd0) begin errors++; $display("FAIL enz_valid: got %b/%0d expected 1/0", bus.OUT_WRITE_VALID, bus.GRANT_ID); end
      // The disabled token used a grant slot, so requester 1 is next.
      bus.REQ_VALID = 4'b1111;
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0010) begin errors++; $display("FAIL enz_slot: got %b expected 0010", bus.REQ_CONSUMED); end
      tick();
      bus.REQ_VALID = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.REQ_VALID = 4'b1000;
      set_cons(1'b1);
      tick();
      checks++; if (bus.GRANT_ID !== 2'd3 || bus.OUT_WRITE_VALID !== 1'b1) begin errors++; $display("FAIL rmid_loaded: got %0d/%b expected 3/1", bus.GRANT_ID, bus.OUT_WRITE_VALID); end
      RST_N = 1'b0;
      bus.REQ_VALID = 4'b1111;
      #1;
      checks++; if (bus.REQ_CONSUMED !== 4'b0000) begin errors++; $display("FAIL rmid_consumed: got %b expected 0000", bus.REQ_CONSUMED); end
      tick();
      RST_N = 1'b1;
      #1;
      checks++; if (bus.OUT_WRITE_VALID !== 1'b0 || bus.OUT_EN_WRITE_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valids: got %b%b expected 00", bus.OUT_WRITE_VALID, bus.OUT_EN_WRITE_VALID); end
      checks++; if (bus.REQ_CONSUMED !== 4'b0001) begin errors++; $display("FAIL rmid_first: got %b expected 0001", bus.REQ_CONSUMED); end
      tick();
      checks++; if (bus.GRANT_ID !== 2'd0) begin errors++; $display("FAIL rmid_grant: got %0d expected 0", bus.GRANT_ID); end
      bus.REQ_VALID = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      logic [NREQ-1:0] exp;
      for (int n = 0; n < 400; n++) begin
         RST_N = ($urandom_range(0, 39) != 0);
         bus.REQ_VALID = 4'($urandom);
         bus.REQ_EN_WRITE = 4'($urandom);
         bus.REQ_WRITE = {$urandom, $urandom, $urandom, $urandom};
         set_cons($urandom_range(0, 3) != 0);
         #1;
         exp = model_consumed();
         checks++; if (bus.REQ_CONSUMED !== exp) begin errors++; $display("FAIL rand_consumed[%0d]: got %b expected %b", n, bus.REQ_CONSUMED, exp); end
         checks++; if (bus.OUT_WRITE_VALID !== m_full || bus.OUT_EN_WRITE_VALID !== m_full) begin errors++; $display("FAIL rand_valid[%0d]: got %b%b expected %b", n, bus.OUT_WRITE_VALID, bus.OUT_EN_WRITE_VALID, m_full); end
         checks++; if (bus.OUT_WRITE !== m_data || bus.OUT_EN_WRITE !== m_en) begin errors++; $display("FAIL rand_token[%0d]: got %h/%b expected %h/%b", n, bus.OUT_WRITE, bus.OUT_EN_WRITE, m_data, m_en); end
         checks++; if (bus.GRANT_ID !== m_src) begin errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", n, bus.GRANT_ID, m_src); end
         tick();
      end
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0;
      bus.REQ_WRITE = '0;
      bus.REQ_EN_WRITE = '0;
      bus.REQ_VALID = '0;
      set_cons(1'b0);
      model_reset();
      @(negedge CLK);
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_wrap();
      test_en_zero();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
